// File: rtl/mb_result_packer.sv
// rtl/mb_result_packer.sv - drains 1024-bit MB result FIFO entries as 512-bit stream beats
module mb_result_packer #(
  parameter int IN_W         = 1024,
  parameter int OUT_W        = 512,
  parameter int WORDS_PER_MB = 1,
  parameter int CNT_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       mb_w,
  input  logic [9:0]       mb_h,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [IN_W-1:0]  fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_FETCH = 3'd2,
    S_LATCH = 3'd3,
    S_SEND0 = 3'd4,
    S_SEND1 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Two output beats per FIFO entry, WORDS_PER_MB entries per macroblock.
  localparam logic [CNT_W-1:0] LP_BEATS_PER_MB = CNT_W'(WORDS_PER_MB * 2);
  localparam logic [CNT_W-1:0] LP_ONE          = CNT_W'(1);

  state_t           r_state;
  logic [9:0]       r_mb_w;
  logic [9:0]       r_mb_h;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_sent_cnt;
  logic [IN_W-1:0]  r_hold;

  logic [CNT_W-1:0] w_total;
  logic             w_send;
  logic             w_accept;
  logic             w_is_last;

  // Frame beat total from the latched dimensions, wrapped to the counter width.
  always_comb begin
    w_total = CNT_W'(r_mb_w) * CNT_W'(r_mb_h) * LP_BEATS_PER_MB;
  end

  assign w_send    = (r_state == S_SEND0) || (r_state == S_SEND1);
  assign w_accept  = w_send && m_ready;
  // The counter only ever reaches total-1 while the final beat is presented.
  assign w_is_last = (r_sent_cnt == (r_total - LP_ONE));

  // Pop only while fetching and only when the FIFO has data, so no pop is ever lost.
  assign fifo_rd = (r_state == S_FETCH) && !fifo_empty;
  assign m_valid = w_send;
  assign m_last  = w_send && w_is_last;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

  // Beat data is a pure slice of the holding register, so it stays stable under backpressure.
  always_comb begin
    m_data = '0;
    if (r_state == S_SEND0) begin
      m_data = r_hold[OUT_W-1:0];
    end else if (r_state == S_SEND1) begin
      m_data = r_hold[OUT_W +: OUT_W];
    end
  end

  // Frame sequencer: fetch one entry, latch it, send its two halves, repeat until total beats sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mb_w     <= '0;
      r_mb_h     <= '0;
      r_total    <= '0;
      r_sent_cnt <= '0;
      r_hold     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mb_w  <= mb_w;
            r_mb_h  <= mb_h;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_total    <= w_total;
          r_sent_cnt <= '0;
          r_state    <= (w_total == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH: begin
          if (!fifo_empty) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_hold  <= fifo_dout;
          r_state <= S_SEND0;
        end
        S_SEND0: begin
          if (w_accept) begin
            r_sent_cnt <= r_sent_cnt + LP_ONE;
            r_state    <= S_SEND1;
          end
        end
        S_SEND1: begin
          if (w_accept) begin
            r_sent_cnt <= r_sent_cnt + LP_ONE;
            r_state    <= w_is_last ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
